data_memory_ctrl: RTL

Parametrised, byte-addressed, little-endian 32-bit data memory with a valid/ready request and response handshake. It supports byte, half and word loads and stores, with sign or zero extension on loads and true byte-lane stores that preserve untouched bytes. It detects misaligned, out-of-range and invalid-size accesses, and inserts a configurable number of wait states to model slow memory. It sits between the core's MEM stage and the data store.

---
 rtl/data_memory_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian 32-bit data memory behind valid/ready request and response channels.
// Byte/half/word access with load extension, fault detection and WAIT_STATES extra cycles per access.
module data_memory_ctrl #(
   parameter int unsigned DEPTH_WORDS = 64,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  mem_size,
   input  logic        signed_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_fault
);
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state_q;
   logic [7:0]    cnt_q;
   logic          wr_q, uns_q, fault_q;
   logic [1:0]    size_q, lane_q;
   logic [IW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic          req_ready_q, resp_valid_q, resp_fault_q;
   logic [31:0]   resp_rdata_q;
   logic [31:0]   mem [DEPTH_WORDS];

   // Addresses below BASE_ADDR wrap to a huge offset, so one compare covers both range limits.
   logic [32:0] off_d;
   logic        fault_d;
   assign off_d   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
   assign fault_d = (mem_size == 2'b00)
                  | ((mem_size == 2'b10) & req_addr[0])
                  | ((mem_size == 2'b11) & (|req_addr[1:0]))
                  | (off_d >= SPAN);

   logic        access_edge;
   assign access_edge = (state_q == ACCESS) && (cnt_q == 8'd0);

   logic [31:0] word_rd, load_d, wlanes_d;
   logic [15:0] half_rd;
   logic [7:0]  byte_rd;
   logic [3:0]  be_d;
   always_comb begin
      word_rd  = mem[idx_q];
      byte_rd  = word_rd[8*lane_q +: 8];
      half_rd  = lane_q[1] ? word_rd[31:16] : word_rd[15:0];
      load_d   = word_rd;
      be_d     = 4'b1111;
      wlanes_d = wdata_q;
      case (size_q)
         2'b01: begin
            load_d   = {{24{~uns_q & byte_rd[7]}}, byte_rd};
            be_d     = 4'b0001 << lane_q;
            wlanes_d = {4{wdata_q[7:0]}};
         end
         2'b10: begin
            load_d   = {{16{~uns_q & half_rd[15]}}, half_rd};
            be_d     = lane_q[1] ? 4'b1100 : 4'b0011;
            wlanes_d = {2{wdata_q[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n && access_edge && wr_q && !fault_q) begin
         for (int b = 0; b < 4; b++) begin
            if (be_d[b]) mem[idx_q][8*b +: 8] <= wlanes_d[8*b +: 8];
         end
      end
   end

   // Faulty requests also pass through ACCESS for one cycle so every response has the same minimum latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= 8'd0;
         wr_q         <= 1'b0;
         uns_q        <= 1'b0;
         fault_q      <= 1'b0;
         size_q       <= 2'b00;
         lane_q       <= 2'b00;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  wr_q        <= req_write;
                  uns_q       <= signed_unsigned;
                  size_q      <= mem_size;
                  lane_q      <= req_addr[1:0];
                  idx_q       <= off_d[IW+1:2];
                  wdata_q     <= req_wdata;
                  fault_q     <= fault_d;
                  cnt_q       <= fault_d ? 8'd0 : 8'(WAIT_STATES);
                  req_ready_q <= 1'b0;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= fault_q;
                  resp_rdata_q <= (wr_q || fault_q) ? 32'd0 : load_d;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_fault_q <= 1'b0;
                  resp_rdata_q <= 32'd0;
                  req_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_rdata = resp_rdata_q;
endmodule
